// File: rtl/seg7_word_reader.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_word_reader
//  Description : Recovers the 3-bit UPC code from the six active-low HEX
//                digit patterns (HEX5 first) of a displayed item word,
//                received one digit per accepted cycle.
//                Optional macro FRAME_TIMEOUT_EN enables an idle-cycle
//                abort of partially received frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_word_reader #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] digit_in,
    input  logic       digit_valid,
    input  logic       sop,
    output logic       in_ready,
    output logic [2:0] code_out,
    output logic       match,
    output logic       code_valid,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [6:0]  c_BLANK       = 7'h7F;
    localparam logic [2:0]  c_NO_CODE     = 3'b111;
    localparam logic [2:0]  c_LAST_IDX    = 3'd5;

    // Words in display order HEX5..HEX0, most significant digit first.
    localparam logic [41:0] c_WORD_GOAT   = {7'h10, 7'h40, 7'h08, 7'h07, 7'h7F, 7'h7F};
    localparam logic [41:0] c_WORD_FISH   = {7'h0E, 7'h7B, 7'h12, 7'h09, 7'h7F, 7'h7F};
    localparam logic [41:0] c_WORD_POTATO = {7'h0C, 7'h40, 7'h07, 7'h08, 7'h07, 7'h40};
    localparam logic [41:0] c_WORD_GUCCI  = {7'h10, 7'h41, 7'h46, 7'h46, 7'h7B, 7'h7F};
    localparam logic [41:0] c_WORD_BEATS  = {7'h03, 7'h06, 7'h08, 7'h07, 7'h12, 7'h7F};
    localparam logic [41:0] c_WORD_PEEP   = {7'h0C, 7'h06, 7'h06, 7'h0C, 7'h7F, 7'h7F};

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [0:5][6:0]   buf_q, buf_d;       // index 0 holds HEX5
    logic [2:0]        code_q, code_d;
    logic              match_q, match_d;
    logic              abort_d;

    logic              accept;
    logic [41:0]       frame_word;
    logic [2:0]        lk_code;
    logic              lk_match;

    assign in_ready   = (state_q != S_DONE);
    assign accept     = digit_valid && in_ready;
    assign code_out   = code_q;
    assign match      = match_q;
    assign code_valid = (state_q == S_DONE);

    // The last digit is compared straight from the input so the result can
    // be registered in the cycle it is accepted.
    assign frame_word = {buf_q[0:4], digit_in};

`ifdef FRAME_TIMEOUT_EN
    logic [TO_W-1:0]   to_cnt_q;
    logic              frame_err_q;
    logic              timeout_hit;

    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign frame_err   = frame_err_q;

    // Idle-cycle counter: runs only while collecting and no digit is taken.
    always_ff @(posedge clk) begin
        if (reset || (state_q != S_COLLECT) || accept) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // One-cycle abort indication following a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= abort_d;
        end
    end
`else
    logic [TO_W-1:0]   unused_timeout;

    assign unused_timeout = TO_W'(TIMEOUT);
    assign frame_err      = 1'b0;
`endif

    // Table lookup of the complete frame; unknown words map to the no-code.
    always_comb begin
        lk_code  = c_NO_CODE;
        lk_match = 1'b1;
        case (frame_word)
            c_WORD_GOAT:   lk_code = 3'b000;
            c_WORD_FISH:   lk_code = 3'b001;
            c_WORD_POTATO: lk_code = 3'b011;
            c_WORD_GUCCI:  lk_code = 3'b100;
            c_WORD_BEATS:  lk_code = 3'b101;
            c_WORD_PEEP:   lk_code = 3'b110;
            default: begin
                lk_code  = c_NO_CODE;
                lk_match = 1'b0;
            end
        endcase
    end

    // Next-state logic: frame assembly, restart on sop, result capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        code_d  = code_q;
        match_d = match_q;
        abort_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && sop) begin
                    buf_d[0] = digit_in;
                    idx_d    = 3'd1;
                    state_d  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    if (sop) begin
                        buf_d[0] = digit_in;
                        idx_d    = 3'd1;
                    end else if (idx_q == c_LAST_IDX) begin
                        buf_d[5] = digit_in;
                        code_d   = lk_code;
                        match_d  = lk_match;
                        idx_d    = 3'd0;
                        state_d  = S_DONE;
                    end else begin
                        buf_d[idx_q] = digit_in;
                        idx_d        = idx_q + 3'd1;
                    end
                end
`ifdef FRAME_TIMEOUT_EN
                else if (timeout_hit) begin
                    buf_d   = {6{c_BLANK}};
                    idx_d   = 3'd0;
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // State, buffer and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            buf_q   <= {6{c_BLANK}};
            code_q  <= c_NO_CODE;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            code_q  <= code_d;
            match_q <= match_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_word_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_word_reader
//  Description : Self-checking bench for seg7_word_reader. Directed frames
//                plus randomized frames checked against a table-search model.
//                Timeout scenarios are built when FRAME_TIMEOUT_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_word_reader;

    typedef logic [0:5][6:0] frame_t;   // element 0 is HEX5

    logic       clk;
    logic       reset;
    logic [6:0] digit_in;
    logic       digit_valid;
    logic       sop;
    logic       in_ready;
    logic [2:0] code_out;
    logic       match;
    logic       code_valid;
    logic       frame_err;

    int n_vec = 0;
    int n_err = 0;

    frame_t     tbl_word [6];
    logic [2:0] tbl_code [6];

    seg7_word_reader #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .sop         (sop),
        .in_ready    (in_ready),
        .code_out    (code_out),
        .match       (match),
        .code_valid  (code_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: search the word table for an exact frame match.
    function automatic void ref_decode(input frame_t f, output logic [2:0] c, output logic m);
        c = 3'b111;
        m = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (f == tbl_word[k]) begin
                c = tbl_code[k];
                m = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then wait to the following negedge.
    task automatic put(input logic v, input logic s, input logic [6:0] d);
        digit_valid = v;
        sop         = s;
        digit_in    = d;
        @(negedge clk);
    endtask

    // Send digits lo..hi of f, random idle gaps before each later digit.
    task automatic send_range(input frame_t f, input int lo, input int hi,
                              input int maxgap, input logic first_sop,
                              input logic completes);
        for (int i = lo; i <= hi; i++) begin
            if (i > lo) begin
                int g;
                g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
                for (int j = 0; j < g; j++) begin
                    put(1'b0, 1'($urandom), 7'($urandom));
                    chk("gap_no_valid", {7'd0, code_valid}, 8'd0);
                end
            end
            put(1'b1, (i == lo) ? first_sop : 1'b0, f[i]);
            if (!(completes && i == hi))
                chk("mid_no_valid", {7'd0, code_valid}, 8'd0);
        end
    endtask

    // Called right after the completing digit: check DONE cycle and after.
    task automatic expect_result(input string tag, input frame_t f);
        logic [2:0] ec;
        logic       em;
        ref_decode(f, ec, em);
        chk({tag, "_cv"},    {7'd0, code_valid}, 8'd1);
        chk({tag, "_code"},  {5'd0, code_out},   {5'd0, ec});
        chk({tag, "_match"}, {7'd0, match},      {7'd0, em});
        chk({tag, "_rdy0"},  {7'd0, in_ready},   8'd0);
        put(1'b0, 1'b0, 7'h7F);
        chk({tag, "_cv_off"}, {7'd0, code_valid}, 8'd0);
        chk({tag, "_hold"},   {4'd0, match, code_out}, {4'd0, em, ec});
        chk({tag, "_rdy1"},   {7'd0, in_ready},  8'd1);
    endtask

    initial begin : main
        frame_t goat, fish, potato, gucci, beats, peep, blank, fishx, rf;
        tbl_word[0] = {7'h10, 7'h40, 7'h08, 7'h07, 7'h7F, 7'h7F}; tbl_code[0] = 3'b000;
        tbl_word[1] = {7'h0E, 7'h7B, 7'h12, 7'h09, 7'h7F, 7'h7F}; tbl_code[1] = 3'b001;
        tbl_word[2] = {7'h0C, 7'h40, 7'h07, 7'h08, 7'h07, 7'h40}; tbl_code[2] = 3'b011;
        tbl_word[3] = {7'h10, 7'h41, 7'h46, 7'h46, 7'h7B, 7'h7F}; tbl_code[3] = 3'b100;
        tbl_word[4] = {7'h03, 7'h06, 7'h08, 7'h07, 7'h12, 7'h7F}; tbl_code[4] = 3'b101;
        tbl_word[5] = {7'h0C, 7'h06, 7'h06, 7'h0C, 7'h7F, 7'h7F}; tbl_code[5] = 3'b110;
        goat   = tbl_word[0];
        fish   = tbl_word[1];
        potato = tbl_word[2];
        gucci  = tbl_word[3];
        beats  = tbl_word[4];
        peep   = tbl_word[5];
        blank  = {6{7'h7F}};
        fishx  = fish;
        fishx[5] = 7'h7E;

        // Reset state
        reset = 1'b1;
        digit_valid = 1'b0;
        sop = 1'b0;
        digit_in = 7'h7F;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_cv",    {7'd0, code_valid}, 8'd0);
        chk("rst_code",  {5'd0, code_out},   8'h07);
        chk("rst_match", {7'd0, match},      8'd0);
        chk("rst_rdy",   {7'd0, in_ready},   8'd1);
        chk("rst_ferr",  {7'd0, frame_err},  8'd0);

        // Goat back-to-back
        send_range(goat, 0, 5, 0, 1'b1, 1'b1);
        expect_result("goat", goat);

        // Potato with three idle cycles between digits 2 and 3
        send_range(potato, 0, 1, 0, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            put(1'b0, 1'b0, 7'h00);
            chk("potato_gap", {7'd0, code_valid}, 8'd0);
        end
        send_range(potato, 2, 5, 0, 1'b0, 1'b1);
        expect_result("potato", potato);

        // All-blank and corrupted fish: no match
        send_range(blank, 0, 5, 0, 1'b1, 1'b1);
        expect_result("blank", blank);
        send_range(fishx, 0, 5, 0, 1'b1, 1'b1);
        expect_result("fishx", fishx);

        // Partial beats, then sop restart with peep
        send_range(beats, 0, 2, 0, 1'b1, 1'b0);
        send_range(peep, 0, 5, 0, 1'b1, 1'b1);
        expect_result("restart", peep);

        // Reset in mid-frame discards the partial frame
        send_range(gucci, 0, 3, 0, 1'b1, 1'b0);
        reset = 1'b1;
        put(1'b0, 1'b0, 7'h7F);
        reset = 1'b0;
        chk("mrst_cv",    {7'd0, code_valid}, 8'd0);
        chk("mrst_code",  {5'd0, code_out},   8'h07);
        chk("mrst_match", {7'd0, match},      8'd0);
        send_range(gucci, 1, 5, 0, 1'b0, 1'b0);   // no sop: all dropped in IDLE
        put(1'b0, 1'b0, 7'h7F);
        chk("mrst_nosop", {7'd0, code_valid}, 8'd0);
        send_range(gucci, 0, 5, 0, 1'b1, 1'b1);
        expect_result("gucci", gucci);

        // Digit with sop offered in the DONE cycle must be dropped
        send_range(fish, 0, 5, 0, 1'b1, 1'b1);
        chk("done_cv", {7'd0, code_valid}, 8'd1);
        put(1'b1, 1'b1, goat[0]);
        send_range(goat, 1, 5, 0, 1'b0, 1'b0);
        put(1'b0, 1'b0, 7'h7F);
        chk("done_drop", {7'd0, code_valid}, 8'd0);
        chk("done_code", {5'd0, code_out},   8'h01);
        send_range(beats, 0, 5, 0, 1'b1, 1'b1);
        expect_result("after_done", beats);

`ifdef FRAME_TIMEOUT_EN
        // Timeout abort after 16 idle cycles
        send_range(beats, 0, 1, 0, 1'b1, 1'b0);
        for (int j = 1; j <= 16; j++) begin
            put(1'b0, 1'b0, 7'h7F);
            chk("to_ferr", {7'd0, frame_err}, (j == 16) ? 8'd1 : 8'd0);
        end
        put(1'b0, 1'b0, 7'h7F);
        chk("to_ferr_off", {7'd0, frame_err}, 8'd0);
        send_range(beats, 2, 5, 0, 1'b0, 1'b0);   // stale frame is gone
        put(1'b0, 1'b0, 7'h7F);
        chk("to_no_cv", {7'd0, code_valid}, 8'd0);
        send_range(goat, 0, 5, 0, 1'b1, 1'b1);
        expect_result("to_goat", goat);
        // Digit on the 16th idle cycle wins
        send_range(peep, 0, 1, 0, 1'b1, 1'b0);
        for (int j = 0; j < 15; j++) put(1'b0, 1'b0, 7'h7F);
        send_range(peep, 2, 5, 0, 1'b0, 1'b1);
        chk("to_race_ferr", {7'd0, frame_err}, 8'd0);
        expect_result("to_race", peep);
`else
        // Without timeout a long stall mid-frame is harmless
        send_range(peep, 0, 1, 0, 1'b1, 1'b0);
        for (int j = 0; j < 40; j++) put(1'b0, 1'b0, 7'h7F);
        chk("stall_ferr", {7'd0, frame_err}, 8'd0);
        send_range(peep, 2, 5, 0, 1'b0, 1'b1);
        expect_result("stall", peep);
`endif

        // Randomized frames against the table-search model
        for (int n = 0; n < 60; n++) begin
            int sel;
            sel = $urandom_range(0, 3);
            rf = tbl_word[$urandom_range(0, 5)];
            if (sel == 2) begin
                int k;
                k = $urandom_range(0, 5);
                rf[k] = rf[k] ^ 7'(1 << $urandom_range(0, 6));
            end else if (sel == 3) begin
                for (int k = 0; k < 6; k++)
                    rf[k] = ($urandom_range(0, 1) == 1) ? 7'h7F : 7'($urandom);
            end
            send_range(rf, 0, 5, 2, 1'b1, 1'b1);
            expect_result("rand", rf);
            chk("rand_ferr", {7'd0, frame_err}, 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_word_reader.md
Name: seg7_word_reader

Overview:
- Inverse of the product-word 7-segment display decoder: receives the six HEX digit patterns of a displayed item word, one digit per clock, and recovers the 3-bit UPC code.
- Sits between a display-snooping/serial source and checkout logic, letting the bench and downstream logic confirm which item word is on HEX5..HEX0.
- Segment patterns are active-low, bit order 6543210, and a blank digit is 7'h7F.

Parameters:
- TIMEOUT, 16, idle cycles allowed between digits inside a frame before abort; used only with FRAME_TIMEOUT_EN.
- TO_W, 5, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- digit_in  input  7  segment pattern of the current digit, active-low.
- digit_valid  input  1  digit_in is valid this cycle.
- sop  input  1  qualifies digit_valid; marks the HEX5 (first) digit of a frame.
- in_ready  output  1  block accepts a digit this cycle.
- code_out  output  3  recovered UPC code.
- match  output  1  frame matched a table word.
- code_valid  output  1  one-cycle pulse; code_out and match are valid.
- frame_err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Accept condition: digit_valid && in_ready. Digits arrive in order HEX5, HEX4, HEX3, HEX2, HEX1, HEX0.
- Word table, hex values listed HEX5..HEX0:
  - 000 goat: 10 40 08 07 7F 7F
  - 001 fish: 0E 7B 12 09 7F 7F
  - 011 potato: 0C 40 07 08 07 40
  - 100 gucci: 10 41 46 46 7B 7F
  - 101 beats: 03 06 08 07 12 7F
  - 110 peep: 0C 06 06 0C 7F 7F
  - Codes 010 and 111 have no word. An all-blank frame is a no-match.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - in_ready=1.
  - An accepted digit with sop=1 stores digit 0, sets idx=1, moves to COLLECT.
  - An accepted digit with sop=0 is discarded; state stays IDLE.
- COLLECT:
  - in_ready=1.
  - An accepted digit with sop=0 stores at idx and increments idx.
  - An accepted digit with sop=1 restarts the frame: stores as digit 0, idx=1.
  - When the digit at idx=5 is accepted, the full frame is compared against the table in the same cycle, the result is registered, and the state moves to DONE.
- DONE (exactly one cycle):
  - in_ready=0; any offered digit is dropped, including one with sop.
  - code_valid=1, then return to IDLE.
- Latency: code_valid is asserted in the cycle after the 6th digit is accepted.
- Result encoding:
  - match=1 and code_out=table code on an exact 42-bit compare.
  - Otherwise match=0 and code_out=3'b111.
- code_out and match hold their last values until the next DONE.
- Reset (any cycle, including mid-frame): state=IDLE, idx=0, digit buffer=7'h7F per digit, code_out=3'b111, match=0, code_valid=0, frame_err=0, in_ready=1 in the cycle after reset deasserts. A partial frame is discarded with no code_valid.
- idx counts 0..5 only and never wraps past 5.

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- Defined:
  - In COLLECT, a counter increments each cycle with no accepted digit and clears on an accepted digit.
  - When the counter reaches TIMEOUT, the state returns to IDLE, the buffer is discarded, frame_err pulses for 1 cycle, and no code_valid is produced.
  - If an accepted digit arrives in the same cycle the counter would reach TIMEOUT, the digit wins and there is no abort.
- Not defined: no counter; frame_err is tied to 0; COLLECT waits indefinitely.

Test Plan:
- Goat frame 10,40,08,07,7F,7F on consecutive cycles with sop on the first -> code_valid one cycle after the 6th digit; code_out=000, match=1.
- Potato frame with 3 idle cycles inserted between digits 2 and 3 (macro off) -> code_out=011, match=1; code_valid pulses exactly once.
- Frame 7F×6, then fish with HEX0=7E -> both frames give match=0, code_out=111.
- Beats digits 03,06,08, then sop with peep 0C,06,06,0C,7F,7F -> single result code_out=110, match=1.
- Reset asserted after 4 gucci digits, then a full gucci frame -> no pulse for the partial frame; second frame gives code_out=100. Separately, a digit offered in the DONE cycle is ignored (in_ready=0) and the next frame still decodes.
- FRAME_TIMEOUT_EN, TIMEOUT=16: 2 digits then 16 idle cycles -> frame_err pulses; the following goat frame gives 000, match=1. With a digit arriving on the 16th idle cycle -> no abort.
